timer_device: RTL



---
 rtl/timer_device.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/timer_device.sv
// ----------------------------------------------------------------------------
// timer_device
//
// Memory-mapped 16-bit down-counting timer with an 8-bit prescaler and a
// level interrupt. Sits in one device slot and shares the 8-bit tri-state
// data bus with memory and the other devices.
//
// Register map (address -> register):
//   0x0 CTRL      bit0 RUN, bit1 AUTORELOAD, bit2 IRQ_EN
//   0x1 STATUS    bit0 EXPIRED (sticky, write 1 to clear), bit1 RUN (ro)
//   0x2 RELOAD_LO 0x3 RELOAD_HI
//   0x4 COUNT_LO  read also captures count[15:8] into the HI snapshot
//   0x5 COUNT_HI  read returns the snapshot, write loads count[15:8]
//   0x6 PRESCALE  tick every PRESCALE+1 clocks
//   0x7-0xF       read 0x00, writes ignored
//
// Ports:
//   clk       system clock
//   reset     synchronous, active-high reset
//   address   register select
//   enable    device selected this cycle
//   mode      1 = write (bus to device), 0 = read (device to bus)
//   data_in   write data from the shared bus
//   data_out  read data; high-Z unless enable && !mode
//   interrupt level interrupt request (EXPIRED & IRQ_EN)
// ----------------------------------------------------------------------------
module timer_device #(
    parameter int DATA_WIDTH           = 8,
    parameter int DEVICE_ADDRESS_WIDTH = 4
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [DEVICE_ADDRESS_WIDTH-1:0] address,
    input  logic                            enable,
    input  logic                            mode,
    input  logic [DATA_WIDTH-1:0]           data_in,
    output logic [DATA_WIDTH-1:0]           data_out,
    output logic                            interrupt
);

    localparam logic [DEVICE_ADDRESS_WIDTH-1:0] ADDR_CTRL      = 'h0;
    localparam logic [DEVICE_ADDRESS_WIDTH-1:0] ADDR_STATUS    = 'h1;
    localparam logic [DEVICE_ADDRESS_WIDTH-1:0] ADDR_RELOAD_LO = 'h2;
    localparam logic [DEVICE_ADDRESS_WIDTH-1:0] ADDR_RELOAD_HI = 'h3;
    localparam logic [DEVICE_ADDRESS_WIDTH-1:0] ADDR_COUNT_LO  = 'h4;
    localparam logic [DEVICE_ADDRESS_WIDTH-1:0] ADDR_COUNT_HI  = 'h5;
    localparam logic [DEVICE_ADDRESS_WIDTH-1:0] ADDR_PRESCALE  = 'h6;

    logic        run_reg,        run_next;
    logic        autoreload_reg, autoreload_next;
    logic        irq_en_reg,     irq_en_next;
    logic        expired_reg,    expired_next;
    logic [15:0] reload_reg,     reload_next;
    logic [15:0] count_reg,      count_next;
    logic [7:0]  prescale_reg,   prescale_next;
    logic [7:0]  p_reg,          p_next;
    logic [7:0]  snapshot_reg,   snapshot_next;

    logic                  bus_write;
    logic                  bus_read;
    logic                  ctrl_write;
    logic                  count_write;
    logic                  tick;
    logic                  expire_event;
    logic [DATA_WIDTH-1:0] read_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            run_reg        <= 1'b0;
            autoreload_reg <= 1'b0;
            irq_en_reg     <= 1'b0;
            expired_reg    <= 1'b0;
            reload_reg     <= 16'h0000;
            count_reg      <= 16'h0000;
            prescale_reg   <= 8'h00;
            p_reg          <= 8'h00;
            snapshot_reg   <= 8'h00;
        end else begin
            run_reg        <= run_next;
            autoreload_reg <= autoreload_next;
            irq_en_reg     <= irq_en_next;
            expired_reg    <= expired_next;
            reload_reg     <= reload_next;
            count_reg      <= count_next;
            prescale_reg   <= prescale_next;
            p_reg          <= p_next;
            snapshot_reg   <= snapshot_next;
        end
    end

    always_comb begin
        bus_write       = enable && mode;
        bus_read        = enable && !mode;
        ctrl_write      = bus_write && (address == ADDR_CTRL);
        count_write     = bus_write && ((address == ADDR_COUNT_LO) || (address == ADDR_COUNT_HI));
        tick            = run_reg && (p_reg == prescale_reg);
        expire_event    = 1'b0;

        run_next        = run_reg;
        autoreload_next = autoreload_reg;
        irq_en_next     = irq_en_reg;
        expired_next    = expired_reg;
        reload_next     = reload_reg;
        count_next      = count_reg;
        prescale_next   = prescale_reg;
        snapshot_next   = snapshot_reg;

        // p free-runs modulo 256, so a PRESCALE lowered below p wraps through 255.
        if (ctrl_write || !run_reg || tick) begin
            p_next = 8'h00;
        end else begin
            p_next = p_reg + 8'd1;
        end

        if (ctrl_write) begin
            run_next        = data_in[0];
            autoreload_next = data_in[1];
            irq_en_next     = data_in[2];
        end

        // A tick is dropped entirely when software writes the count, and also
        // when the same-cycle CTRL write stops the timer (run_next is then 0).
        if (tick && !count_write && run_next) begin
            if (count_reg != 16'h0000) begin
                count_next = count_reg - 16'd1;
            end else begin
                expire_event = 1'b1;
                if (autoreload_next) begin
                    count_next = reload_reg;
                end else if (!ctrl_write) begin
                    run_next = 1'b0;
                end
            end
        end

        if (bus_write) begin
            case (address)
                ADDR_RELOAD_LO: reload_next[7:0]  = data_in;
                ADDR_RELOAD_HI: reload_next[15:8] = data_in;
                ADDR_COUNT_LO:  count_next[7:0]   = data_in;
                ADDR_COUNT_HI:  count_next[15:8]  = data_in;
                ADDR_PRESCALE:  prescale_next     = data_in;
                ADDR_STATUS:    if (data_in[0]) expired_next = 1'b0;
                default: ;
            endcase
        end

        // Set has priority over a same-cycle clear.
        if (expire_event) begin
            expired_next = 1'b1;
        end

        // Latching the high byte on a low-byte read gives a coherent 16-bit read.
        if (bus_read && (address == ADDR_COUNT_LO)) begin
            snapshot_next = count_reg[15:8];
        end
    end

    always_comb begin
        read_data = 8'h00;
        case (address)
            ADDR_CTRL:      read_data = {5'b00000, irq_en_reg, autoreload_reg, run_reg};
            ADDR_STATUS:    read_data = {6'b000000, run_reg, expired_reg};
            ADDR_RELOAD_LO: read_data = reload_reg[7:0];
            ADDR_RELOAD_HI: read_data = reload_reg[15:8];
            ADDR_COUNT_LO:  read_data = count_reg[7:0];
            ADDR_COUNT_HI:  read_data = snapshot_reg;
            ADDR_PRESCALE:  read_data = prescale_reg;
            default:        read_data = 8'h00;
        endcase
    end

    assign data_out  = (enable && !mode) ? read_data : {DATA_WIDTH{1'bz}};
    assign interrupt = expired_reg & irq_en_reg;

endmodule
